// File: rtl/noc_pkg.sv
// Shared NoC definitions: direction codes, default sizing and the
// round-robin channel selector used by the output-port arbiters.
package noc_pkg;

  localparam logic [3:0] DIR_NONE = 4'd0;
  localparam logic [3:0] DIR_N    = 4'd1;
  localparam logic [3:0] DIR_E    = 4'd2;
  localparam logic [3:0] DIR_W    = 4'd3;
  localparam logic [3:0] DIR_S    = 4'd4;
  localparam logic [3:0] DIR_L    = 4'd5;

  localparam int DEF_DATASIZE = 40;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_WIDTH    = 3;

  // Which input channel currently holds round-robin priority (E, S, L).
  typedef enum logic [1:0] {
    RR_CH2 = 2'd0,
    RR_CH4 = 2'd1,
    RR_CH5 = 2'd2
  } rr_sel_e;

endpackage

// File: rtl/op_00_if.sv
// Bundle of route-computation inputs and downstream link signals for an
// output-port unit. The master side is the surrounding router fabric, the
// slave side is the output-port unit itself.
interface op_00_if #(
  parameter int DATASIZE = 40,
  parameter int WIDTH    = 3
);

  logic [DATASIZE-1:0] data_in_2;
  logic [3:0]          direction_in_2;
  logic                rc_ready_2;
  logic [DATASIZE-1:0] data_in_4;
  logic [3:0]          direction_in_4;
  logic                rc_ready_4;
  logic [DATASIZE-1:0] data_in_5;
  logic [3:0]          direction_in_5;
  logic                rc_ready_5;
  logic [DATASIZE-1:0] data_out;
  logic                valid_out;
  logic                ready_in;
  logic [WIDTH:0]      pressure_out;

  modport master (
    output data_in_2, direction_in_2, data_in_4, direction_in_4,
           data_in_5, direction_in_5, ready_in,
    input  rc_ready_2, rc_ready_4, rc_ready_5, data_out, valid_out,
           pressure_out
  );

  modport slave (
    input  data_in_2, direction_in_2, data_in_4, direction_in_4,
           data_in_5, direction_in_5, ready_in,
    output rc_ready_2, rc_ready_4, rc_ready_5, data_out, valid_out,
           pressure_out
  );

endinterface

// File: rtl/op_rr_arb3.sv
// Three-input round-robin arbiter. Bit 0 is the E channel, bit 1 the S
// channel, bit 2 the L channel; the pointer marks who is searched first.
module op_rr_arb3
  import noc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       enable,
  output logic [2:0] grant
);

  rr_sel_e rr_ptr;
  rr_sel_e rr_ptr_next;

  // Pick the first requester at or after the pointer in cyclic order.
  always_comb begin
    grant = 3'b000;
    if (enable) begin
      case (rr_ptr)
        RR_CH4: begin
          if      (req[1]) grant = 3'b010;
          else if (req[2]) grant = 3'b100;
          else if (req[0]) grant = 3'b001;
        end
        RR_CH5: begin
          if      (req[2]) grant = 3'b100;
          else if (req[0]) grant = 3'b001;
          else if (req[1]) grant = 3'b010;
        end
        default: begin
          if      (req[0]) grant = 3'b001;
          else if (req[1]) grant = 3'b010;
          else if (req[2]) grant = 3'b100;
        end
      endcase
    end
  end

  // Priority passes to the channel following the winner; idle cycles keep it.
  always_comb begin
    rr_ptr_next = rr_ptr;
    if (grant[0]) rr_ptr_next = RR_CH4;
    if (grant[1]) rr_ptr_next = RR_CH5;
    if (grant[2]) rr_ptr_next = RR_CH2;
  end

  // Pointer register, restarting at the E channel.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= RR_CH2;
    else     rr_ptr <= rr_ptr_next;
  end

endmodule

// File: rtl/op_00.sv
// Output-port unit for router node (0,0): arbitrates the E, S and L
// route-computation channels, buffers winners in a first-word-fall-through
// FIFO and reports FIFO occupancy as back-pressure to neighbours.
module op_00
  import noc_pkg::*;
#(
  parameter int         DATASIZE = DEF_DATASIZE,
  parameter int         DEPTH    = DEF_DEPTH,
  parameter int         WIDTH    = DEF_WIDTH,
  parameter logic [3:0] PORT_DIR = DIR_E
) (
  input  logic  op_clk,
  input  logic  rst,
  op_00_if.slave bus
);

  localparam logic [WIDTH:0] FULL_COUNT = (WIDTH+1)'(DEPTH);

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [WIDTH-1:0]    rd_ptr;
  logic [WIDTH-1:0]    wr_ptr;
  logic [WIDTH:0]      count;
  logic [2:0]          req;
  logic [2:0]          grant;
  logic                enable;
  logic                push;
  logic                pop;
  logic [DATASIZE-1:0] wr_data;

  assign req[0] = (bus.direction_in_2 == PORT_DIR);
  assign req[1] = (bus.direction_in_4 == PORT_DIR);
  assign req[2] = (bus.direction_in_5 == PORT_DIR);

  // No grants while full (even if a pop is in flight) or while in reset.
  assign enable = !rst && (count < FULL_COUNT);

  op_rr_arb3 u_arb (
    .clk    (op_clk),
    .rst    (rst),
    .req    (req),
    .enable (enable),
    .grant  (grant)
  );

  assign bus.rc_ready_2 = grant[0];
  assign bus.rc_ready_4 = grant[1];
  assign bus.rc_ready_5 = grant[2];

  assign push = |grant;
  assign pop  = bus.valid_out && bus.ready_in;

  // Route the winning channel's flit towards the FIFO write port.
  always_comb begin
    wr_data = '0;
    if      (grant[0]) wr_data = bus.data_in_2;
    else if (grant[1]) wr_data = bus.data_in_4;
    else if (grant[2]) wr_data = bus.data_in_5;
  end

  // FIFO storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge op_clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop cancel.
  always_ff @(posedge op_clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + WIDTH'(1);
      if (push && !pop)      count <= count + (WIDTH+1)'(1);
      else if (pop && !push) count <= count - (WIDTH+1)'(1);
    end
  end

  // Head is forced to zero when empty so never-written entries stay hidden.
  assign bus.data_out     = (count != '0) ? mem[rd_ptr] : '0;
  assign bus.valid_out    = (count != '0);
  assign bus.pressure_out = count;

  a_no_overflow: assert property (@(posedge op_clk) disable iff (rst)
    !(push && !pop && count == FULL_COUNT));

  a_no_underflow: assert property (@(posedge op_clk) disable iff (rst)
    !(pop && count == '0));

endmodule

// File: tb/tb_op_00.sv
// Self-checking bench for op_00: a behavioural model predicts grants,
// occupancy and the flit order; a separate monitor checks popped flits.
module tb_op_00;
  import noc_pkg::*;

  localparam int DS = 40;
  localparam int DP = 8;

  logic op_clk = 1'b0;
  logic rst;

  op_00_if #(.DATASIZE(DS), .WIDTH(3)) bus ();

  op_00 #(.DATASIZE(DS), .DEPTH(DP), .WIDTH(3), .PORT_DIR(DIR_E)) dut (
    .op_clk (op_clk),
    .rst    (rst),
    .bus    (bus)
  );

  // Free-running clock.
  always #5 op_clk = ~op_clk;

  int checks   = 0;
  int failures = 0;

  logic [DS-1:0] sb [$];
  int            exp_count  = 0;
  int            rr_idx     = 0;
  bit            model_init = 1'b0;
  int            pend_grant = -1;
  logic [DS-1:0] pend_data  = '0;
  bit            pend_pop   = 1'b0;
  bit [2:0]      last_grant = 3'b000;

  function automatic void checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [3:0] chDir(int i);
    case (i)
      0:       return bus.direction_in_2;
      1:       return bus.direction_in_4;
      default: return bus.direction_in_5;
    endcase
  endfunction

  function automatic logic [DS-1:0] chData(int i);
    case (i)
      0:       return bus.data_in_2;
      1:       return bus.data_in_4;
      default: return bus.data_in_5;
    endcase
  endfunction

  function automatic void setData(int i, logic [DS-1:0] v);
    case (i)
      0:       bus.data_in_2 = v;
      1:       bus.data_in_4 = v;
      default: bus.data_in_5 = v;
    endcase
  endfunction

  function automatic void setDir(int i, logic [3:0] v);
    case (i)
      0:       bus.direction_in_2 = v;
      1:       bus.direction_in_4 = v;
      default: bus.direction_in_5 = v;
    endcase
  endfunction

  function automatic logic [DS-1:0] randFlit();
    return DS'({$urandom(), $urandom()});
  endfunction

  // Model: predict this cycle's grant/outputs and stage the edge update.
  always @(negedge op_clk) begin
    int g;
    logic [2:0] exp_rdy;
    if (model_init) begin
      g = -1;
      if (!rst && exp_count < DP)
        for (int k = 0; k < 3; k++)
          if (g < 0 && chDir((rr_idx + k) % 3) == DIR_E) g = (rr_idx + k) % 3;
      exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
      checkOutput("rc_ready{5,4,2}",
                  64'({bus.rc_ready_5, bus.rc_ready_4, bus.rc_ready_2}), 64'(exp_rdy));
      checkOutput("valid_out", 64'(bus.valid_out), 64'(exp_count != 0));
      checkOutput("pressure_out", 64'(bus.pressure_out), 64'(exp_count));
      pend_grant = g;
      pend_data  = (g >= 0) ? chData(g) : '0;
      pend_pop   = !rst && exp_count != 0 && bus.ready_in;
    end
  end

  // Model: commit the staged update on the clock edge.
  always @(posedge op_clk) begin
    if (rst) begin
      sb.delete();
      exp_count  = 0;
      rr_idx     = 0;
      model_init = 1'b1;
      last_grant = 3'b000;
      pend_grant = -1;
      pend_pop   = 1'b0;
    end else if (model_init) begin
      last_grant = 3'b000;
      if (pend_grant >= 0) begin
        sb.push_back(pend_data);
        last_grant[pend_grant] = 1'b1;
        rr_idx = (pend_grant + 1) % 3;
        exp_count++;
      end
      if (pend_pop) exp_count--;
    end
  end

  // Monitor: every downstream handshake must deliver the oldest expected flit.
  always @(negedge op_clk) begin
    logic [DS-1:0] exp_flit;
    if (model_init && !rst && bus.valid_out && bus.ready_in) begin
      if (sb.size() == 0) begin
        checkOutput("pop_on_empty_model", 64'(1), 64'(0));
      end else begin
        exp_flit = sb.pop_front();
        checkOutput("data_out", 64'(bus.data_out), 64'(exp_flit));
      end
    end
  end

  // One clock step; granted channels then present a fresh flit.
  task automatic nextCycle();
    @(posedge op_clk);
    #1;
    for (int i = 0; i < 3; i++)
      if (last_grant[i]) setData(i, randFlit());
  endtask

  task automatic applyStimulus(input logic [3:0] d2, input logic [3:0] d4,
                               input logic [3:0] d5, input logic rdy, input int cycles);
    bus.direction_in_2 = d2;
    bus.direction_in_4 = d4;
    bus.direction_in_5 = d5;
    bus.ready_in       = rdy;
    repeat (cycles) nextCycle();
  endtask

  task automatic applyReset(input int cycles);
    rst = 1'b1;
    repeat (cycles) nextCycle();
    rst = 1'b0;
  endtask

  // Random traffic; a requesting channel holds its flit until granted.
  task automatic randomTraffic(input int cycles, input int ready_pct);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!(chDir(i) == DIR_E && !last_grant[i])) begin
          setDir(i, ($urandom_range(0, 1) == 1) ? DIR_E : 4'($urandom_range(0, 5)));
          setData(i, randFlit());
        end
      end
      bus.ready_in = ($urandom_range(0, 99) < ready_pct);
      nextCycle();
    end
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    rst                = 1'b1;
    bus.ready_in       = 1'b0;
    bus.direction_in_2 = DIR_E;
    bus.direction_in_4 = DIR_E;
    bus.direction_in_5 = DIR_E;
    bus.data_in_2      = randFlit();
    bus.data_in_4      = randFlit();
    bus.data_in_5      = randFlit();

    applyReset(2);
    applyStimulus(DIR_E, DIR_NONE, DIR_NONE, 1'b1, 1);
    applyStimulus(DIR_NONE, DIR_NONE, DIR_NONE, 1'b1, 3);

    bus.data_in_4 = 40'hA5;
    applyStimulus(DIR_NONE, DIR_E, DIR_NONE, 1'b0, 1);
    applyStimulus(DIR_NONE, DIR_NONE, DIR_NONE, 1'b0, 2);
    applyStimulus(DIR_NONE, DIR_NONE, DIR_NONE, 1'b1, 3);

    applyReset(1);
    applyStimulus(DIR_E, DIR_E, DIR_E, 1'b1, 12);
    applyStimulus(DIR_NONE, DIR_NONE, DIR_NONE, 1'b1, 3);

    applyReset(1);
    applyStimulus(DIR_NONE, DIR_NONE, DIR_E, 1'b0, 11);
    applyStimulus(DIR_NONE, DIR_NONE, DIR_E, 1'b1, 1);
    applyStimulus(DIR_NONE, DIR_NONE, DIR_E, 1'b0, 2);
    applyStimulus(DIR_NONE, DIR_NONE, DIR_NONE, 1'b1, 10);

    applyStimulus(DIR_S, DIR_NONE, DIR_NONE, 1'b1, 4);

    applyStimulus(DIR_E, DIR_E, DIR_E, 1'b0, 5);
    applyReset(1);
    applyStimulus(DIR_NONE, DIR_E, DIR_NONE, 1'b1, 3);
    applyStimulus(DIR_NONE, DIR_NONE, DIR_NONE, 1'b1, 2);

    randomTraffic(300, 20);
    randomTraffic(300, 85);
    randomTraffic(200, 50);
    applyStimulus(DIR_NONE, DIR_NONE, DIR_NONE, 1'b1, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
